// File: rtl/ni_rx_buffer.sv
// ni_rx_buffer
//   Receive-side network-interface buffer between the router local output
//   port and the ddma receive engine. Accepts flits under credit-based flow
//   control into a circular FIFO. It parses packet framing (header, size,
//   payload) and tags every stored flit with start/end-of-packet. It also
//   counts how many complete packets are held, so the ddma arbiter only
//   grants the memory bus when a whole packet can be drained.
//
// Ports
//   clock      : system clock, rising edge
//   reset      : asynchronous active-low reset
//   rx         : router presents a flit this cycle
//   data_in    : flit from router
//   credit_out : buffer can accept a flit this cycle
//   out_valid  : head flit available to ddma
//   out_data   : head flit
//   out_sop    : head flit is a header flit
//   out_eop    : head flit is the last flit of its packet
//   out_ready  : ddma consumes head flit
//   pkt_avail  : at least one complete packet is buffered
//   pkt_count  : number of complete packets buffered
//   overflow   : sticky, a flit arrived while credit_out was 0
module ni_rx_buffer #(
  parameter int FLIT_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rx,
  input  logic [FLIT_WIDTH-1:0]      data_in,
  output logic                       credit_out,
  output logic                       out_valid,
  output logic [FLIT_WIDTH-1:0]      out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  input  logic                       out_ready,
  output logic                       pkt_avail,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = FLIT_WIDTH + 2;

  typedef enum logic [1:0] {
    P_HEADER  = 2'd0,
    P_SIZE    = 2'd1,
    P_PAYLOAD = 2'd2
  } pstate_t;

  // Each entry is {sop, eop, flit}
  logic [EW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  pstate_t               pstate;
  logic [FLIT_WIDTH-1:0] remaining;

  logic                  wr_en;
  logic                  rd_en;
  logic                  tag_sop;
  logic                  tag_eop;
  logic [EW-1:0]         head;

  // Credit is derived from the registered count and the reset input, so it
  // drops the moment reset is asserted and no accepted flit can be lost.
  assign credit_out = reset && (count != CW'(DEPTH));
  assign wr_en      = rx && credit_out;
  assign out_valid  = (count != '0);
  assign rd_en      = out_valid && out_ready;

  // Storage is not reset, so the tag bits are qualified with out_valid to
  // keep out_sop/out_eop low while the FIFO is empty.
  assign head      = mem[rd_ptr];
  assign out_data  = head[FLIT_WIDTH-1:0];
  assign out_sop   = out_valid && head[FLIT_WIDTH+1];
  assign out_eop   = out_valid && head[FLIT_WIDTH];
  assign pkt_avail = (pkt_count != '0);

  // Framing tags for the flit being written, from the current parser state
  always_comb begin
    tag_sop = 1'b0;
    tag_eop = 1'b0;
    case (pstate)
      P_HEADER:  tag_sop = 1'b1;
      P_SIZE:    tag_eop = (data_in == '0);
      P_PAYLOAD: tag_eop = (remaining == FLIT_WIDTH'(1));
      default:   tag_sop = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= {tag_sop, tag_eop, data_in};
    end
  end

  // FIFO control; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count + CW'(wr_en) - CW'(rd_en);
      pkt_count <= pkt_count + CW'(wr_en && tag_eop) - CW'(rd_en && out_eop);
      if (rx && !credit_out) begin
        overflow <= 1'b1;
      end
    end
  end

  // Packet parser, advanced only by accepted writes so dropped flits are
  // invisible to the framing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pstate    <= P_HEADER;
      remaining <= '0;
    end else if (wr_en) begin
      case (pstate)
        P_HEADER: begin
          pstate <= P_SIZE;
        end
        P_SIZE: begin
          remaining <= data_in;
          pstate    <= (data_in == '0) ? P_HEADER : P_PAYLOAD;
        end
        P_PAYLOAD: begin
          remaining <= remaining - FLIT_WIDTH'(1);
          if (remaining == FLIT_WIDTH'(1)) begin
            pstate <= P_HEADER;
          end
        end
        default: begin
          pstate <= P_HEADER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ni_rx_buffer.sv
// tb_ni_rx_buffer
//   Self-checking bench for ni_rx_buffer (FLIT_WIDTH=16, DEPTH=8).
//   A packet-level reference model (queue of tagged flits plus the flit
//   position inside the current packet) predicts every output each cycle.
module tb_ni_rx_buffer;

  localparam int FW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clock;
  logic          reset;
  logic          rx;
  logic [FW-1:0] data_in;
  logic          credit_out;
  logic          out_valid;
  logic [FW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          out_ready;
  logic          pkt_avail;
  logic [CW-1:0] pkt_count;
  logic          overflow;

  ni_rx_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data_in    (data_in),
    .credit_out (credit_out),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_ready  (out_ready),
    .pkt_avail  (pkt_avail),
    .pkt_count  (pkt_count),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [FW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  int            m_pos;    // index of the next flit within its packet
  int            m_size;   // payload length of the current packet
  logic          m_ovf;
  logic [FW-1:0] src[$];   // flits still to be offered by the stimulus

  task automatic model_reset();
    mq.delete();
    m_pos  = 0;
    m_size = 0;
    m_ovf  = 1'b0;
  endtask

  function automatic int model_pkts();
    int c = 0;
    foreach (mq[i]) if (mq[i].eop) c++;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [FW-1:0] d, input logic rdy);
    @(negedge clock);
    rx        = r;
    data_in   = d;
    out_ready = rdy;
    #1;
  endtask

  task automatic check_model();
    int np;
    np = model_pkts();
    chk("credit_out", {31'd0, credit_out}, {31'd0, mq.size() != DEPTH});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("out_data", {16'd0, out_data}, {16'd0, mq[0].d});
      chk("out_sop", {31'd0, out_sop}, {31'd0, mq[0].sop});
      chk("out_eop", {31'd0, out_eop}, {31'd0, mq[0].eop});
    end
    chk("pkt_count", 32'(pkt_count), 32'(np));
    chk("pkt_avail", {31'd0, pkt_avail}, {31'd0, np != 0});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  // Apply the driven inputs to the model, then let the DUT clock them in
  task automatic advance();
    logic wr, rd;
    ent_t e;
    wr = rx && (mq.size() != DEPTH);
    rd = out_ready && (mq.size() != 0);
    if (rx && !wr) m_ovf = 1'b1;
    if (rd) void'(mq.pop_front());
    if (wr) begin
      e.d = data_in;
      if (m_pos == 0) begin
        e.sop = 1'b1; e.eop = 1'b0; m_pos = 1;
      end else if (m_pos == 1) begin
        m_size = int'(data_in);
        e.sop = 1'b0; e.eop = (m_size == 0);
        m_pos = (m_size == 0) ? 0 : 2;
      end else begin
        e.sop = 1'b0; e.eop = (m_pos == m_size + 1);
        m_pos = e.eop ? 0 : m_pos + 1;
      end
      mq.push_back(e);
    end
    @(posedge clock);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b0; rx = 1'b0; data_in = '0; out_ready = 1'b0;
    #1;
    chk("rst_credit", {31'd0, credit_out}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic push_pkt(input logic [FW-1:0] hdr, input int size, input logic [FW-1:0] base);
    src.push_back(hdr);
    src.push_back(FW'(size));
    for (int i = 0; i < size; i++) src.push_back(base + FW'(i));
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * DEPTH && mq.size() != 0; k++) begin
      drive(1'b0, '0, 1'b1); check_model(); advance();
    end
    drive(1'b0, '0, 1'b0);
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
  endtask

  // ---------------- table of directed vectors ----------------
  typedef struct {
    logic          rx;
    logic [FW-1:0] d;
    logic          rdy;
    logic          v;
    logic [FW-1:0] q;
    logic          sop;
    logic          eop;
    int            pc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] cur;
    logic          r, rdy;
    int            guard;

    // Single packet, then zero-size packet followed by a header
    tbl[0]  = '{1'b1, 16'h0102, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 16'h0102, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b1, 16'hAAAA, 1'b0, 1'b1, 16'h0102, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 16'hBBBB, 1'b0, 1'b1, 16'h0102, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0102, 1'b1, 1'b0, 1};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b1, 1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
    tbl[10] = '{1'b1, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 0};
    tbl[11] = '{1'b1, 16'h0007, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 1};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, 0};
    tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0};

    reset = 1'b0; rx = 1'b0; data_in = '0; out_ready = 1'b0;
    model_reset();
    reset_dut();

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rx, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].v});
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_data", i), {16'd0, out_data}, {16'd0, tbl[i].q});
        chk($sformatf("tbl%0d_sop", i), {31'd0, out_sop}, {31'd0, tbl[i].sop});
        chk($sformatf("tbl%0d_eop", i), {31'd0, out_eop}, {31'd0, tbl[i].eop});
      end
      chk($sformatf("tbl%0d_pkt_count", i), 32'(pkt_count), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_pkt_avail", i), {31'd0, pkt_avail}, {31'd0, tbl[i].pc != 0});
      advance();
    end

    // Full FIFO, dropped ninth flit, credit returning after one read
    reset_dut();
    src.delete();
    push_pkt(16'h0F00, 6, 16'h6000);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, src[i], 1'b0); check_model(); advance();
    end
    drive(1'b1, 16'hDEAD, 1'b0);
    chk("full_credit", {31'd0, credit_out}, 32'd0);
    check_model(); advance();
    drive(1'b0, '0, 1'b0);
    chk("overflow_set", {31'd0, overflow}, 32'd1);
    check_model(); advance();
    drive(1'b0, '0, 1'b1); check_model(); advance();
    drive(1'b0, '0, 1'b0);
    chk("credit_back", {31'd0, credit_out}, 32'd1);
    check_model(); advance();
    drain();

    // Asynchronous reset in the middle of a payload clears sticky overflow
    src.delete();
    push_pkt(16'h0011, 5, 16'h1100);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, src[i], 1'b0); check_model(); advance();
    end
    #2;
    reset = 1'b0; rx = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_pkt_count", 32'(pkt_count), 32'd0);
    chk("async_overflow", {31'd0, overflow}, 32'd0);
    chk("async_credit", {31'd0, credit_out}, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    model_reset();
    drive(1'b1, 16'h0009, 1'b0); check_model(); advance();
    drive(1'b0, '0, 1'b0);
    chk("post_reset_sop", {31'd0, out_sop}, 32'd1);
    chk("post_reset_data", {16'd0, out_data}, 32'h0009);
    check_model(); advance();

    // Wrap-around: 20 flits with out_ready toggling each cycle
    reset_dut();
    src.delete();
    push_pkt(16'h00A0, 18, 16'hA100);
    guard = 0;
    while (src.size() != 0 && guard < 200) begin
      r = (mq.size() != DEPTH);
      drive(r, src[0], guard[0]); check_model();
      if (r) void'(src.pop_front());
      advance();
      guard++;
    end
    chk("wrap_done", 32'(src.size()), 32'd0);
    drain();

    // Long packet larger than the FIFO, ddma always draining
    reset_dut();
    src.delete();
    push_pkt(16'h0C00, 12, 16'hC000);
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, src[i], 1'b1);
      chk($sformatf("long_avail_early%0d", i), {31'd0, pkt_avail}, 32'd0);
      check_model(); advance();
    end
    drive(1'b0, '0, 1'b1);
    chk("long_avail", {31'd0, pkt_avail}, 32'd1);
    chk("long_eop", {31'd0, out_eop}, 32'd1);
    check_model(); advance();
    drive(1'b0, '0, 1'b0);
    chk("long_avail_clear", {31'd0, pkt_avail}, 32'd0);
    check_model(); advance();

    // Randomized packet stream with random backpressure
    reset_dut();
    src.delete();
    for (int c = 0; c < 500; c++) begin
      if (src.size() == 0)
        push_pkt(FW'($urandom), int'($urandom_range(0, 10)), FW'($urandom));
      cur = src[0];
      r   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      drive(r, cur, rdy); check_model();
      if (r && mq.size() != DEPTH) void'(src.pop_front());
      advance();
    end
    drain();

    rx = 1'b0; out_ready = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ni_rx_buffer.md
Name: ni_rx_buffer

Overview:
- Receive-side network-interface buffer between the router local output port and the ddma receive engine.
- Accepts flits under credit-based flow control and stores them in a circular FIFO.
- Parses packet framing (header flit, size flit, payload flits) and tags each stored flit with start/end-of-packet.
- Presents flits to the ddma over a valid/ready handshake and reports whether a complete packet is buffered, so the ddma arbiter grants the memory bus to receive only when a whole packet can be drained.

Parameters:
FLIT_WIDTH, 16, width of one flit and of the size field
DEPTH, 8, FIFO depth in flits; power of two, >= 4

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rx  in  1  router presents a flit this cycle
data_in  in  FLIT_WIDTH  flit from router
credit_out  out  1  buffer can accept a flit this cycle
out_valid  out  1  head flit available to ddma
out_data  out  FLIT_WIDTH  head flit
out_sop  out  1  head flit is a header flit
out_eop  out  1  head flit is last flit of its packet
out_ready  in  1  ddma consumes head flit
pkt_avail  out  1  at least one complete packet (eop written) is in the FIFO
pkt_count  out  $clog2(DEPTH+1)  number of complete packets in the FIFO
overflow  out  1  sticky: a flit arrived while credit_out was 0

Behaviour:
- Reset (reset low, asynchronous): wr_ptr, rd_ptr, count, pkt_count = 0; parser state = P_HEADER; payload counter = 0; overflow = 0; credit_out forced 0. Outputs out_valid, out_sop, out_eop, pkt_avail = 0. Storage contents are don't-care.
- credit_out = reset && (count != DEPTH). Combinational from registered count, so no flit is lost under correct use.
- Write: occurs when rx && credit_out. Stores {sop, eop, data_in} at wr_ptr, and wr_ptr wraps modulo DEPTH.
- rx while credit_out == 0: flit is dropped, overflow is set, and the parser does not advance.
- Read: occurs when out_valid && out_ready; rd_ptr wraps modulo DEPTH. out_valid = (count != 0).
  - out_data, out_sop and out_eop are driven from the entry at rd_ptr.
  - out_ready while empty has no effect.
- count next state: count + write - read.
  - Simultaneous read and write when full: the write is blocked because credit_out is 0; count becomes DEPTH-1.
  - Simultaneous read and write when empty: count becomes 1. There is no bypass.
- Latency: a flit written in cycle N is visible on out_* in cycle N+1.
- Parser FSM, advanced only on accepted writes:
  - P_HEADER: tag sop=1, eop=0 -> P_SIZE.
  - P_SIZE: latch data_in as remaining payload count (unsigned FLIT_WIDTH). Tag sop=0.
    - If data_in == 0: eop=1 -> P_HEADER.
    - Otherwise: eop=0 -> P_PAYLOAD.
  - P_PAYLOAD: decrement remaining. Tag eop = (remaining == 1).
    - When remaining == 1 -> P_HEADER.
    - Otherwise stay in P_PAYLOAD.
- pkt_count: +1 on a write with eop=1, -1 on a read of an eop flit, and both in the same cycle leave it unchanged. pkt_avail = (pkt_count != 0).
- Packets larger than DEPTH are legal. They stream through without pkt_avail asserting until the eop flit has been written.
- overflow clears only on reset.
- Reset asserted mid-packet: all state is discarded and the next accepted flit is parsed as a header.

Test Plan:
- Single packet: reset, then rx of header 0x0102, size 0x0002, payloads 0xAAAA and 0xBBBB on consecutive cycles with out_ready=0 -> count=4, pkt_count=1, pkt_avail=1. Then out_ready=1 -> out_data 0x0102(sop=1), 0x0002, 0xAAAA, 0xBBBB(eop=1) on consecutive cycles, after which pkt_count=0 and out_valid=0.
- Zero-size packet: header 0x0005, size 0x0000 -> size flit tagged eop=1, pkt_count=1. The next flit 0x0007 is tagged sop=1.
- Full and backpressure (DEPTH=8): 8 writes with out_ready=0 -> credit_out=0. A 9th rx is dropped and overflow=1, and the stored contents are unchanged. One read -> credit_out=1 the same cycle the count drops to 7.
- Wrap-around: 20 flits streamed with out_ready toggling every cycle -> output order equals input order, pointers wrap, and count never exceeds 8.
- Long packet: size 12 with DEPTH=8 and the ddma draining -> pkt_avail stays 0 until the 14th flit (eop) is written, then pulses to 1 until that flit is read.
- Asynchronous reset mid-payload: reset low for 1 cycle after 3 payload flits -> out_valid=0, pkt_count=0, overflow=0 immediately. Next rx of 0x0009 is tagged sop=1.
